sysid_checker: RTL and testbench

SYSID_CHECKER -- requirements
Module: sysid_checker

---
 rtl/sysid_checker.sv | 163 ++++++++++++++++
 tb/tb_sysid_checker.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_checker.sv
// rtl/sysid_checker.sv - reads system ID and timestamp over Avalon-MM and compares them to expected values
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd651202559,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1277427864,
  parameter logic [15:0] TIMEOUT_CYCLES     = 16'd255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [1:0] {S_IDLE, S_RD_ID, S_RD_TS, S_CMP} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_auto_start;
  logic [15:0] r_count;
  logic        r_avm_address;
  logic        r_avm_read;
  logic        r_busy;
  logic        r_done;
  logic        r_id_ok;
  logic        r_ts_ok;
  logic        r_timeout;
  logic [31:0] r_id_value;
  logic [31:0] r_ts_value;

  logic [15:0] w_count_d;
  logic        w_avm_address_d;
  logic        w_avm_read_d;
  logic        w_busy_d;
  logic        w_done_d;
  logic        w_id_ok_d;
  logic        w_ts_ok_d;
  logic        w_timeout_d;
  logic [31:0] w_id_value_d;
  logic [31:0] w_ts_value_d;

  logic        w_start;
  logic        w_limit;

  assign w_start = start | r_auto_start;
  assign w_limit = (TIMEOUT_CYCLES != 16'd0) && (r_count == TIMEOUT_CYCLES);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_auto_start  <= AUTO_START;
      r_count       <= 16'd0;
      r_avm_address <= 1'b0;
      r_avm_read    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_id_ok       <= 1'b0;
      r_ts_ok       <= 1'b0;
      r_timeout     <= 1'b0;
      r_id_value    <= 32'd0;
      r_ts_value    <= 32'd0;
    end else begin
      r_state       <= w_next_state;
      r_auto_start  <= 1'b0;
      r_count       <= w_count_d;
      r_avm_address <= w_avm_address_d;
      r_avm_read    <= w_avm_read_d;
      r_busy        <= w_busy_d;
      r_done        <= w_done_d;
      r_id_ok       <= w_id_ok_d;
      r_ts_ok       <= w_ts_ok_d;
      r_timeout     <= w_timeout_d;
      r_id_value    <= w_id_value_d;
      r_ts_value    <= w_ts_value_d;
    end
  end

  // An accepted read always wins over an expiring timeout in the same cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next_state = S_RD_ID;
      S_RD_ID: begin
        if (!avm_waitrequest) w_next_state = S_RD_TS;
        else if (w_limit)     w_next_state = S_IDLE;
      end
      S_RD_TS: begin
        if (!avm_waitrequest) w_next_state = S_CMP;
        else if (w_limit)     w_next_state = S_IDLE;
      end
      S_CMP:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_avm_read_d    = (w_next_state == S_RD_ID) || (w_next_state == S_RD_TS);
    w_avm_address_d = (w_next_state == S_RD_TS);
    w_busy_d        = (w_next_state != S_IDLE);
    w_done_d        = 1'b0;
    w_count_d       = r_count;
    w_id_ok_d       = r_id_ok;
    w_ts_ok_d       = r_ts_ok;
    w_timeout_d     = r_timeout;
    w_id_value_d    = r_id_value;
    w_ts_value_d    = r_ts_value;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_count_d    = 16'd0;
          w_id_ok_d    = 1'b0;
          w_ts_ok_d    = 1'b0;
          w_timeout_d  = 1'b0;
          w_id_value_d = 32'd0;
          w_ts_value_d = 32'd0;
        end
      end
      S_RD_ID, S_RD_TS: begin
        if (!avm_waitrequest) begin
          w_count_d = 16'd0;
          if (r_state == S_RD_ID) begin
            w_id_value_d = avm_readdata;
          end else begin
            w_ts_value_d = avm_readdata;
            w_id_ok_d    = (r_id_value == EXPECTED_ID);
            w_ts_ok_d    = (avm_readdata == EXPECTED_TIMESTAMP);
            w_done_d     = 1'b1;
          end
        end else if (w_limit) begin
          w_count_d   = 16'd0;
          w_timeout_d = 1'b1;
          w_id_ok_d   = 1'b0;
          w_ts_ok_d   = 1'b0;
          w_done_d    = 1'b1;
        end else begin
          w_count_d = r_count + 16'd1;
        end
      end
      default: begin
      end
    endcase
  end

  assign avm_address = r_avm_address;
  assign avm_read    = r_avm_read;
  assign busy        = r_busy;
  assign done        = r_done;
  assign id_ok       = r_id_ok;
  assign ts_ok       = r_ts_ok;
  assign timeout     = r_timeout;
  assign id_value    = r_id_value;
  assign ts_value    = r_ts_value;

endmodule

// File: tb/tb_sysid_checker.sv
// tb/tb_sysid_checker.sv - scoreboard bench for sysid_checker
module tb_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd651202559;
  localparam logic [31:0] EXP_TS = 32'd1277427864;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        avm_address, avm_read, avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;

  logic        na_start = 1'b0;
  logic        na_wait = 1'b0;
  logic        na_address, na_read;
  logic [31:0] na_readdata;
  logic        na_busy, na_done, na_id_ok, na_ts_ok, na_timeout;
  logic [31:0] na_id_value, na_ts_value;

  logic [31:0] sl_id = EXP_ID;
  logic [31:0] sl_ts = EXP_TS;
  int          wait_len = 0;
  int          stall_cnt;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          na_done_cnt = 0;
  logic        prev_stall = 1'b0;
  logic        prev_addr = 1'b0;

  typedef struct {
    int          cyc;
    logic        id_ok;
    logic        ts_ok;
    logic        tmo;
    logic        busy;
    logic [31:0] idv;
    logic [31:0] tsv;
  } exp_t;
  exp_t q[$];

  sysid_checker #(.TIMEOUT_CYCLES(16'd4), .AUTO_START(1'b1)) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok), .timeout(timeout),
    .id_value(id_value), .ts_value(ts_value)
  );

  sysid_checker #(.TIMEOUT_CYCLES(16'd0), .AUTO_START(1'b0)) u_na (
    .clk(clk), .reset(reset), .start(na_start),
    .avm_address(na_address), .avm_read(na_read),
    .avm_readdata(na_readdata), .avm_waitrequest(na_wait),
    .busy(na_busy), .done(na_done), .id_ok(na_id_ok), .ts_ok(na_ts_ok), .timeout(na_timeout),
    .id_value(na_id_value), .ts_value(na_ts_value)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave: stalls each read for wait_len cycles before accepting it.
  assign avm_waitrequest = avm_read && (stall_cnt < wait_len);
  assign avm_readdata    = avm_address ? sl_ts : sl_id;
  assign na_readdata     = na_address ? EXP_TS : EXP_ID;

  always @(posedge clk or posedge reset) begin
    if (reset) stall_cnt <= 0;
    else if (!avm_read || !avm_waitrequest) stall_cnt <= 0;
    else stall_cnt <= stall_cnt + 1;
  end

  function automatic void check1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void check32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        check32("done_cycle", cyc, e.cyc);
        check1("id_ok", id_ok, e.id_ok);
        check1("ts_ok", ts_ok, e.ts_ok);
        check1("timeout", timeout, e.tmo);
        check1("busy_at_done", busy, e.busy);
        check1("read_at_done", avm_read, 1'b0);
        check32("id_value", id_value, e.idv);
        check32("ts_value", ts_value, e.tsv);
      end
    end
    if (!reset && prev_stall && !timeout) begin
      check1("hold_read", avm_read, 1'b1);
      check1("hold_addr", avm_address, prev_addr);
    end
    prev_stall = avm_read && avm_waitrequest;
    prev_addr  = avm_address;
    if (na_done) na_done_cnt++;
  end

  function automatic void expect_check(int at, logic [31:0] idv, logic [31:0] tsv, bit tmo);
    exp_t e;
    e.cyc   = at;
    e.tmo   = tmo;
    e.id_ok = !tmo && (idv == EXP_ID);
    e.ts_ok = !tmo && (tsv == EXP_TS);
    e.busy  = !tmo;
    e.idv   = tmo ? 32'd0 : idv;
    e.tsv   = tmo ? 32'd0 : tsv;
    q.push_back(e);
  endfunction

  task automatic issue(int lat, bit tmo);
    @(negedge clk);
    expect_check(cyc + lat, sl_id, sl_ts, tmo);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(int max);
    int n = 0;
    while (q.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    check32("drain_queue", q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check1("rst_read", avm_read, 1'b0);
    check1("rst_addr", avm_address, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_flags", id_ok | ts_ok | timeout, 1'b0);
    check32("rst_id_value", id_value, 32'd0);
    check32("rst_ts_value", ts_value, 32'd0);

    // Auto-start after release behaves like a start in the release cycle.
    expect_check(cyc + 3, sl_id, sl_ts, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check1("auto_busy", busy, 1'b1);
    check1("na_no_auto", na_busy, 1'b0);
    drain(20);
    check1("hold_id_ok", id_ok, 1'b1);
    check1("idle_busy", busy, 1'b0);

    // Basic latency: addr 0 then addr 1 then done.
    @(negedge clk);
    expect_check(cyc + 3, sl_id, sl_ts, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check1("lat_read1", avm_read, 1'b1);
    check1("lat_addr1", avm_address, 1'b0);
    @(negedge clk);
    check1("lat_read2", avm_read, 1'b1);
    check1("lat_addr2", avm_address, 1'b1);
    drain(20);

    sl_id = 32'd0;
    issue(3, 1'b0);
    drain(20);
    sl_id = EXP_ID;
    sl_ts = EXP_TS ^ 32'd1;
    issue(3, 1'b0);
    drain(20);
    sl_ts = EXP_TS;

    wait_len = 3;
    issue(9, 1'b0);
    drain(30);
    wait_len = 4;
    issue(11, 1'b0);
    drain(30);

    wait_len = 1000;
    issue(6, 1'b1);
    drain(30);
    check1("tmo_read_low", avm_read, 1'b0);
    check1("tmo_flag_hold", timeout, 1'b1);
    wait_len = 0;
    issue(3, 1'b0);
    drain(20);

    // Start pulses in RD_TS and CMP must not launch another check.
    @(negedge clk);
    expect_check(cyc + 3, sl_id, sl_ts, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    drain(20);
    repeat (8) @(negedge clk);
    check1("no_extra_busy", busy, 1'b0);

    // Timeout disabled: a long stall never aborts.
    @(negedge clk);
    na_wait  = 1'b1;
    na_start = 1'b1;
    @(negedge clk);
    na_start = 1'b0;
    repeat (300) @(negedge clk);
    check1("na_still_busy", na_busy, 1'b1);
    check1("na_still_read", na_read, 1'b1);
    check32("na_no_done", na_done_cnt, 0);
    na_wait = 1'b0;
    n = 0;
    while (na_done_cnt == 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check32("na_done_once", na_done_cnt, 1);
    check1("na_id_ok", na_id_ok, 1'b1);
    check1("na_ts_ok", na_ts_ok, 1'b1);
    check1("na_timeout", na_timeout, 1'b0);

    // Reset in RD_TS aborts at once; auto-start reruns after release.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check1("pre_rst_read", avm_read, 1'b1);
    reset = 1'b1;
    #1;
    check1("async_read", avm_read, 1'b0);
    check1("async_busy", busy, 1'b0);
    @(negedge clk);
    check1("rst_no_done", done, 1'b0);
    expect_check(cyc + 3, sl_id, sl_ts, 1'b0);
    reset = 1'b0;
    drain(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
